// File: rtl/udp_parser_pkg.sv
// Shared widths, framing types and byte-mask helper for the payload sum controller.
package udp_parser_pkg;

  localparam int PAYLOAD_W    = 256;
  localparam int WORD_W       = 32;
  localparam int KEEP_W       = 32;
  localparam int SUM_PIPE_LAT = 3;

  // Wide enough to count SUM_PIPE_LAT flush cycles after reset release.
  localparam int FLUSH_W      = 2;

  // Wide enough to count every L tag that can be in the pipeline at once.
  localparam int LTAG_W       = 2;

  // START means the next accepted beat opens a new packet.
  typedef enum logic {
    PKT_START,
    PKT_BODY
  } pkt_state_e;

  // Framing tag carried alongside each beat through the adder pipeline.
  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  // Zero every byte lane whose keep bit is clear.
  function automatic logic [PAYLOAD_W-1:0] maskPayload(
    input logic [PAYLOAD_W-1:0] data,
    input logic [KEEP_W-1:0]    keep
  );
    logic [PAYLOAD_W-1:0] masked;
    masked = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      masked[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/payload_sum_ctrl_if.sv
// Bundle of payload stream, tree-adder and result-stream signals around the controller.
interface payload_sum_if;
  import udp_parser_pkg::*;

  logic                 en;
  logic [PAYLOAD_W-1:0] in_data;
  logic [KEEP_W-1:0]    in_keep;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] sum_payload;
  logic                 sum_ce;
  logic                 sum_clear;
  logic [WORD_W-1:0]    sum_result;
  logic [WORD_W-1:0]    res_data;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;

  // Environment side: producer, external adder and result consumer.
  modport master (
    output en, in_data, in_keep, in_valid, in_last, sum_result, res_ready,
    input  in_ready, sum_payload, sum_ce, sum_clear, res_data, res_valid, busy
  );

  // Controller side.
  modport slave (
    input  en, in_data, in_keep, in_valid, in_last, sum_result, res_ready,
    output in_ready, sum_payload, sum_ce, sum_clear, res_data, res_valid, busy
  );

endinterface

// File: rtl/sum_result_fifo.sv
// Small synchronous FIFO holding finished packet sums until the consumer pops them.
module sum_result_fifo
  import udp_parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WORD_W-1:0]      i_pushData,
  input  logic                   i_pop,
  output logic [WORD_W-1:0]      o_headData,
  output logic                   o_notEmpty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              w_doPush;
  logic              w_doPop;

  // A pop on an empty FIFO is dropped; a push is taken when there is room or a pop frees one.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != (AW+1)'(DEPTH)) || w_doPop);

  // Entry storage needs no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; push with pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_notEmpty = (r_count != '0);
  assign o_headData = o_notEmpty ? r_mem[r_rdPtr] : '0;
  assign o_count    = r_count;

endmodule

// File: rtl/payload_sum_ctrl.sv
// Frames payload beats into packets for an external pipelined tree adder and queues packet sums.
module payload_sum_ctrl
  import udp_parser_pkg::*;
#(
  parameter int RES_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  payload_sum_if.slave  bus
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  pkt_state_e                     r_pktState;
  tag_t [SUM_PIPE_LAT-1:0]        r_tagPipe;
  logic [FLUSH_W-1:0]             r_flushCnt;

  logic                           w_flushed;
  logic                           w_handshake;
  logic                           w_inReady;
  logic                           w_push;
  tag_t                           w_newTag;
  logic [LTAG_W-1:0]              w_lInFlight;
  logic [CW:0]                    w_pending;
  logic [CW-1:0]                  w_fifoCount;
  logic [WORD_W-1:0]              w_headData;
  logic                           w_notEmpty;

  // The adder pipeline may hold pre-reset data, so input stays closed until it has drained.
  assign w_flushed = (r_flushCnt == FLUSH_W'(SUM_PIPE_LAT));

  // Count packets that are committed to the FIFO but still travelling through the adder.
  always_comb begin
    w_lInFlight = '0;
    for (int s = 0; s < SUM_PIPE_LAT; s++) begin
      w_lInFlight = w_lInFlight + {{(LTAG_W-1){1'b0}}, r_tagPipe[s].last};
    end
  end

  assign w_pending   = {1'b0, w_fifoCount} + (CW+1)'(w_lInFlight);
  assign w_inReady   = bus.en && w_flushed && (w_pending < (CW+1)'(RES_DEPTH));
  assign w_handshake = bus.in_valid && w_inReady;

  // Tag the beat being accepted this cycle with its packet framing.
  always_comb begin
    w_newTag       = '0;
    w_newTag.first = w_handshake && (r_pktState == PKT_START);
    w_newTag.last  = w_handshake && bus.in_last;
  end

  // Packet framing state, tag pipeline and post-reset flush counter; disable drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pktState <= PKT_START;
      r_tagPipe  <= '0;
      r_flushCnt <= '0;
    end else if (!bus.en) begin
      r_pktState <= PKT_START;
      r_tagPipe  <= '0;
    end else begin
      if (!w_flushed) begin
        r_flushCnt <= r_flushCnt + FLUSH_W'(1);
      end
      r_tagPipe <= {r_tagPipe[SUM_PIPE_LAT-2:0], w_newTag};
      if (w_handshake) begin
        r_pktState <= bus.in_last ? PKT_START : PKT_BODY;
      end
    end
  end

  // The accumulator holds the finished sum while the L tag sits in the final stage.
  assign w_push = bus.en && r_tagPipe[SUM_PIPE_LAT-1].last;

  sum_result_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_resFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pushData (bus.sum_result),
    .i_pop      (bus.res_ready),
    .o_headData (w_headData),
    .o_notEmpty (w_notEmpty),
    .o_count    (w_fifoCount)
  );

  assign bus.in_ready    = w_inReady;
  assign bus.sum_ce      = bus.en;
  assign bus.sum_payload = w_handshake ? maskPayload(bus.in_data, bus.in_keep) : '0;
  assign bus.sum_clear   = r_tagPipe[SUM_PIPE_LAT-2].first;
  assign bus.res_data    = w_headData;
  assign bus.res_valid   = w_notEmpty;
  assign bus.busy        = (r_pktState == PKT_BODY) || (|r_tagPipe);

endmodule

// File: tb/tb_payload_sum_ctrl.sv
// Scoreboard bench for payload_sum_ctrl with a behavioural 3-stage tree adder in the loop.
module tb_payload_sum_ctrl;
  import udp_parser_pkg::*;

  localparam int          RES_DEPTH = 4;
  localparam logic [31:0] KEEP_ALL  = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  payload_sum_if bus();

  payload_sum_ctrl #(
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [31:0] expQ[$];
  logic [31:0] monExp;
  int          accepted;
  logic        willAccept;

  // Behavioural adder: word reduction, one register stage, then accumulator; starts with junk.
  logic [31:0] adP1  = 32'h1234_5678;
  logic [31:0] adP2  = 32'h0BAD_F00D;
  logic [31:0] adAcc = 32'hDEAD_BEEF;

  function automatic logic [31:0] wordSum(input logic [255:0] d);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + d[32*k +: 32];
    return s;
  endfunction

  function automatic logic [255:0] wordsOf(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = base + step * k;
    return d;
  endfunction

  function automatic logic [255:0] word0(input logic [31:0] v);
    logic [255:0] d;
    d = '0;
    d[31:0] = v;
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus.sum_ce) begin
      adP1  <= wordSum(bus.sum_payload);
      adP2  <= adP1;
      adAcc <= (bus.sum_clear ? 32'd0 : adAcc) + adP2;
    end
  end

  assign bus.sum_result = adAcc;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one beat (called just after a rising edge) and hold it until accepted.
  task automatic applyStimulus(input logic [255:0] data, input logic [31:0] keep,
                               input logic last, input logic [255:0] expPayload);
    int waitCycles;
    waitCycles   = 0;
    bus.in_data  = data;
    bus.in_keep  = keep;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL readyTimeout: in_ready got 0 expected 1");
    end else begin
      checkOutput("maskedPayload", bus.sum_payload, expPayload);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.in_keep  = '0;
  endtask

  // Wait for every expected result to be popped, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.res_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drainTimeout: %0d results outstanding, expected 0", expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pop handshake is checked against the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpectedResult: got %0h expected none", bus.res_data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("resultData", {224'b0, bus.res_data}, {224'b0, monExp});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.en        = 1'b1;
    bus.in_data   = wordsOf(32'd1, 32'd1);
    bus.in_keep   = KEEP_ALL;
    bus.in_last   = 1'b1;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values, with a beat offered that must not be taken.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady",    bus.in_ready,    0);
    checkOutput("rstSumPayload", bus.sum_payload, 0);
    checkOutput("rstSumClear",   bus.sum_clear,   0);
    checkOutput("rstResValid",   bus.res_valid,   0);
    checkOutput("rstResData",    bus.res_data,    0);
    checkOutput("rstBusy",       bus.busy,        0);

    // Three closed cycles after release while the adder drains.
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("flushReady", bus.in_ready, 0);
    end
    @(negedge clk);
    checkOutput("readyAfterFlush", bus.in_ready, 1);
    checkOutput("sumCeFollowsEn",  bus.sum_ce,   1);
    @(posedge clk);
    #1;

    // Single beat 1..8 = 36: clear two cycles after the handshake, result four cycles after.
    expQ.push_back(32'd36);
    applyStimulus(wordsOf(32'd1, 32'd1), KEEP_ALL, 1'b1, wordsOf(32'd1, 32'd1));
    @(negedge clk);
    checkOutput("clearAtT1", bus.sum_clear, 0);
    @(negedge clk);
    checkOutput("clearAtT2", bus.sum_clear, 1);
    @(negedge clk);
    checkOutput("clearAtT3", bus.sum_clear, 0);
    checkOutput("validAtT3", bus.res_valid, 0);
    @(negedge clk);
    checkOutput("validAtT4", bus.res_valid, 1);
    drain();

    // Three beats of 0x10 words with an idle gap: 0x80 + 0x80 + 0x10 (last beat keeps word 0 only).
    expQ.push_back(32'h110);
    applyStimulus(wordsOf(32'h10, 32'd0), KEEP_ALL, 1'b0, wordsOf(32'h10, 32'd0));
    @(posedge clk);
    #1;
    applyStimulus(wordsOf(32'h10, 32'd0), KEEP_ALL, 1'b0, wordsOf(32'h10, 32'd0));
    applyStimulus(wordsOf(32'h10, 32'd0), 32'h0000_000F, 1'b1, word0(32'h10));
    drain();

    // Back-to-back packets: 60 + 40 = 100, then 5 on the very next cycle.
    expQ.push_back(32'd100);
    expQ.push_back(32'd5);
    applyStimulus(word0(32'd60), KEEP_ALL, 1'b0, word0(32'd60));
    applyStimulus(word0(32'd40), KEEP_ALL, 1'b1, word0(32'd40));
    applyStimulus(word0(32'd5),  KEEP_ALL, 1'b1, word0(32'd5));
    drain();

    // Consumer stalled: exactly RES_DEPTH single-beat packets are accepted, none lost.
    bus.res_ready = 1'b0;
    accepted      = 0;
    bus.in_keep   = KEEP_ALL;
    bus.in_last   = 1'b1;
    bus.in_data   = word0(32'd11);
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      willAccept = bus.in_ready;
      if (willAccept) begin
        expQ.push_back(32'd11 + 32'(accepted));
        accepted++;
      end
      @(posedge clk);
      #1;
      if (willAccept) bus.in_data = word0(32'd11 + 32'(accepted));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checkOutput("acceptedWhenFull", accepted, RES_DEPTH);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("fullResValid", bus.res_valid, 1);
    checkOutput("fullInReady",  bus.in_ready,  0);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    drain();
    @(negedge clk);
    checkOutput("readyAfterDrain", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Disable mid-packet: partial 50 is dropped, held 21 survives, then 7.
    bus.res_ready = 1'b0;
    expQ.push_back(32'd21);
    applyStimulus(word0(32'd21), KEEP_ALL, 1'b1, word0(32'd21));
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(word0(32'd50), KEEP_ALL, 1'b0, word0(32'd50));
    bus.en = 1'b0;
    @(negedge clk);
    checkOutput("sumCeLow", bus.sum_ce, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("busyDiscarded",  bus.busy,      0);
    checkOutput("fifoKeptWhileOff", bus.res_valid, 1);
    checkOutput("readyWhileOff",  bus.in_ready,  0);
    @(posedge clk);
    #1;
    bus.en = 1'b1;
    expQ.push_back(32'd7);
    applyStimulus(word0(32'd7), KEEP_ALL, 1'b1, word0(32'd7));
    repeat (6) @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    drain();

    // Wrap-around: 8 x 0xFFFFFFFF mod 2^32.
    expQ.push_back(32'hFFFF_FFF8);
    applyStimulus(wordsOf(32'hFFFF_FFFF, 32'd0), KEEP_ALL, 1'b1, wordsOf(32'hFFFF_FFFF, 32'd0));
    drain();

    // Reset mid-packet: partial 30 is discarded, next packet 9 stands alone.
    applyStimulus(word0(32'd30), KEEP_ALL, 1'b0, word0(32'd30));
    @(negedge clk);
    checkOutput("busyMidPacket", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady",  bus.in_ready,  0);
    checkOutput("midRstBusy",     bus.busy,      0);
    checkOutput("midRstResValid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.push_back(32'd9);
    applyStimulus(word0(32'd9), KEEP_ALL, 1'b1, word0(32'd9));
    drain();

    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
